// File: rtl/alu_shift_sequencer.sv
// Breaks SLL/SRL/SRA by 0..31 into ALU shift steps of 8, 2 and 1 bits, issuing one step per cycle.
// Optional completed-op counter is built when SHSEQ_PERF_EN is defined.
module alu_shift_sequencer #(
    parameter int CTRL_W = 6,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [5:0]        func,
    input  logic [4:0]        shamt,
    input  logic              flush,
    output logic              busy,
    output logic              step_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              sel_fb,
    output logic              done,
    output logic              bypass,
    output logic              err,
    output logic [PERF_W-1:0] perf_ops
);

    typedef enum logic [2:0] {IDLE, SH8, SH2, SH1, DONE} state_t;

    state_t     state, nxt;
    logic [5:0] func_q, f;
    logic [1:0] n8, n2, c8, c2;
    logic       n1, c1;
    logic       first, issue, fin;

    function automatic logic legal(input logic [5:0] fc);
        return (fc == 6'h00) || (fc == 6'h02) || (fc == 6'h03);
    endfunction

    function automatic state_t pick(input logic [1:0] a8, input logic [1:0] a2, input logic a1);
        if (a8 != 2'd0) return SH8;
        if (a2 != 2'd0) return SH2;
        if (a1) return SH1;
        return DONE;
    endfunction

    function automatic logic [CTRL_W-1:0] code(input logic [5:0] fc, input state_t s);
        logic [4:0] c;
        c = (fc == 6'h00) ? 5'h0A : (fc == 6'h02) ? 5'h0D : 5'h10;
        if (s == SH2) c = c + 5'd1;
        else if (s == SH8) c = c + 5'd2;
        return CTRL_W'(c);
    endfunction

    // In IDLE the step counts come straight from the request; later they come from the counters.
    always_comb begin
        first = (state == IDLE);
        c8    = first ? shamt[4:3] : n8;
        c2    = first ? shamt[2:1] : n2;
        c1    = first ? shamt[0]   : n1;
        f     = first ? func       : func_q;
        nxt   = legal(f) ? pick(c8, c2, c1) : DONE;
        issue = !flush && ((first && start) || state == SH8 || state == SH2 || state == SH1);
        fin   = issue && (nxt == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            func_q     <= '0;
            n8         <= '0;
            n2         <= '0;
            n1         <= 1'b0;
            busy       <= 1'b0;
            step_valid <= 1'b0;
            alu_ctrl   <= '0;
            sel_fb     <= 1'b0;
            done       <= 1'b0;
            bypass     <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            alu_ctrl   <= '0;
            sel_fb     <= 1'b0;
            done       <= 1'b0;
            bypass     <= 1'b0;
            err        <= 1'b0;
            if (issue) begin
                state  <= nxt;
                busy   <= 1'b1;
                func_q <= f;
                n8     <= c8 - {1'b0, nxt == SH8};
                n2     <= c2 - {1'b0, nxt == SH2};
                n1     <= c1 & (nxt != SH1);
                if (fin) begin
                    done   <= 1'b1;
                    bypass <= first && legal(f);
                    err    <= !legal(f);
                end else begin
                    step_valid <= 1'b1;
                    alu_ctrl   <= code(f, nxt);
                    sel_fb     <= !first;
                end
            end else begin
                // flush, the DONE state and IDLE without a request all land in IDLE
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

`ifdef SHSEQ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perf_ops <= '0;
        else if (fin && perf_ops != {PERF_W{1'b1}}) perf_ops <= perf_ops + 1'b1;
    end
`else
    assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Scoreboard bench for alu_shift_sequencer: expected steps/done events are queued with cycle stamps.
module tb_alu_shift_sequencer;
    localparam int CTRL_W = 6;
    localparam int PERF_W = 16;

    logic              clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [5:0]        func = '0;
    logic [4:0]        shamt = '0;
    logic              busy, step_valid, sel_fb, done, bypass, err;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [PERF_W-1:0] perf_ops;

    alu_shift_sequencer #(.CTRL_W(CTRL_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .func(func), .shamt(shamt),
        .flush(flush), .busy(busy), .step_valid(step_valid), .alu_ctrl(alu_ctrl),
        .sel_fb(sel_fb), .done(done), .bypass(bypass), .err(err), .perf_ops(perf_ops)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [5:0] ctrl; logic fb; } step_t;
    typedef struct { int cyc; logic byp; logic er; } done_t;
    step_t sq[$];
    done_t dq[$];
    int errors = 0, checks = 0, exp_perf = 0;

    task automatic push_op(input logic [5:0] f, input logic [4:0] s, input int c0);
        int c;
        logic [5:0] base;
        c = c0 + 1;
        if (!(f == 6'h00 || f == 6'h02 || f == 6'h03)) begin
            dq.push_back('{c, 1'b0, 1'b1});
            return;
        end
        base = (f == 6'h00) ? 6'h0A : (f == 6'h02) ? 6'h0D : 6'h10;
        repeat (int'(s[4:3])) begin sq.push_back('{c, 6'(base + 6'd2), c != c0 + 1}); c++; end
        repeat (int'(s[2:1])) begin sq.push_back('{c, 6'(base + 6'd1), c != c0 + 1}); c++; end
        if (s[0]) begin sq.push_back('{c, base, c != c0 + 1}); c++; end
        dq.push_back('{c, s == 5'd0, 1'b0});
    endtask

    // Called at a negedge: request is held for one cycle, returns at the next negedge.
    task automatic start_op(input logic [5:0] f, input logic [4:0] s);
        func = f; shamt = s; start = 1'b1;
        push_op(f, s, cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int poke_cyc, input bit poke_flush, input int budget);
        step_t e;
        done_t d;
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (step_valid === 1'b1) begin
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL %s stray_step cyc=%0d got ctrl=%h required none", name, cyc, alu_ctrl);
                end else begin
                    e = sq.pop_front();
                    if (cyc !== e.cyc || alu_ctrl !== e.ctrl || sel_fb !== e.fb || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s step got cyc=%0d ctrl=%h fb=%b busy=%b required cyc=%0d ctrl=%h fb=%b busy=1",
                                 name, cyc, alu_ctrl, sel_fb, busy, e.cyc, e.ctrl, e.fb);
                    end
                end
            end else begin
                checks++;
                if (alu_ctrl !== '0 || sel_fb !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_ctrl cyc=%0d got ctrl=%h fb=%b required 00 0", name, cyc, alu_ctrl, sel_fb);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL %s stray_done cyc=%0d got done=1 required 0", name, cyc);
                end else begin
                    d = dq.pop_front();
`ifdef SHSEQ_PERF_EN
                    exp_perf++;
`endif
                    if (cyc !== d.cyc || bypass !== d.byp || err !== d.er || step_valid !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s done got cyc=%0d bypass=%b err=%b sv=%b busy=%b required cyc=%0d bypass=%b err=%b sv=0 busy=1",
                                 name, cyc, bypass, err, step_valid, busy, d.cyc, d.byp, d.er);
                    end
                end
            end else begin
                checks++;
                if (bypass !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s flags_without_done cyc=%0d got bypass=%b err=%b required 0 0", name, cyc, bypass, err);
                end
            end
            if (sq.size() == 0 && dq.size() == 0 && busy === 1'b0) begin ok = 1'b1; break; end
            start = (cyc == poke_cyc) && !poke_flush;
            flush = (cyc == poke_cyc) && poke_flush;
            if (start) begin func = 6'h00; shamt = 5'd1; end
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout got steps_left=%0d dones_left=%0d busy=%b required 0 0 0", name, sq.size(), dq.size(), busy);
        end
        checks++;
        if (perf_ops !== PERF_W'(exp_perf)) begin
            errors++;
            $display("FAIL %s perf_ops got %0d required %0d", name, perf_ops, exp_perf);
        end
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({busy, step_valid, alu_ctrl, sel_fb, done, bypass, err, perf_ops} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b sv=%b ctrl=%h perf=%0d required all 0", busy, step_valid, alu_ctrl, perf_ops);
        end
        reset_n = 1'b1;
        @(negedge clk);
        start_op(6'h00, 5'd5);
        drain("first_after_reset", -1, 1'b0, 20);
        // SRL by 6 sits in SH2 for three cycles; pull reset during the second
        start_op(6'h02, 5'd6);
        @(negedge clk);
        checks++;
        if (step_valid !== 1'b1 || alu_ctrl !== 6'h0E) begin
            errors++;
            $display("FAIL reset_setup got sv=%b ctrl=%h required 1 0e", step_valid, alu_ctrl);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, step_valid, alu_ctrl, sel_fb, done, bypass, err, perf_ops} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b sv=%b ctrl=%h fb=%b perf=%0d required all 0", busy, step_valid, alu_ctrl, sel_fb, perf_ops);
        end
        sq.delete(); dq.delete(); exp_perf = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(6'h03, 5'd3);
        drain("after_reset", -1, 1'b0, 20);
    endtask

    task automatic test_sll27;
        start_op(6'h00, 5'd27);
        drain("sll27", -1, 1'b0, 20);
    endtask

    task automatic test_srl31;
        int c0;
        c0 = cyc;
        start_op(6'h02, 5'd31);
        drain("srl31_start_ignored", c0 + 4, 1'b0, 20);
    endtask

    task automatic test_bypass;
        start_op(6'h03, 5'd0);
        drain("bypass", -1, 1'b0, 10);
    endtask

    task automatic test_err;
        start_op(6'h21, 5'd5);
        drain("illegal_func", -1, 1'b0, 10);
    endtask

    task automatic test_flush;
        int c0;
        c0 = cyc;
        start_op(6'h00, 5'd27);
        while (sq.size() > 3) void'(sq.pop_back());
        dq.delete();
        drain("flush_mid_op", c0 + 3, 1'b1, 20);
        checks++;
        if (cyc !== c0 + 4) begin
            errors++;
            $display("FAIL flush_idle_cycle got %0d required %0d", cyc - c0, 4);
        end
        start = 1'b1; flush = 1'b1; func = 6'h00; shamt = 5'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || step_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_with_flush got busy=%b sv=%b done=%b required 0 0 0", busy, step_valid, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] fs [4];
        fs[0] = 6'h00; fs[1] = 6'h02; fs[2] = 6'h03; fs[3] = 6'h21;
        start_op(6'h00, 5'd1);
        drain("b2b_a", -1, 1'b0, 10);
        start_op(6'h03, 5'd10);
        drain("b2b_b", -1, 1'b0, 10);
        for (int i = 0; i < 12; i++) begin
            start_op(fs[$urandom_range(0, 3)], 5'($urandom_range(0, 31)));
            drain("b2b_rand", -1, 1'b0, 20);
        end
    endtask

    initial begin
        test_reset;
        test_sll27;
        test_srl31;
        test_bypass;
        test_err;
        test_flush;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
